mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported synchronous memory between the instruction fetch unit and the load/store unit of the multi-cycle core. Each requester issues one-cycle request pulses and receives a one-cycle done pulse with read data. The block latches requests, arbitrates round-robin, sequences the fixed-latency memory access, and routes the result back. It sits between the core's fetch/memory units and the unified memory macro.

## Interface
- ADDR_W, 32: address width, byte address passed through unchanged
- DATA_W, 32: data word width
- LATENCY, 2: memory read latency in cycles after the address-sample edge; legal 1..7
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request pulse (read only)
- i_addr  in  ADDR_W  fetch address, sampled when i_req=1
- i_done  out  1  fetch complete pulse
- i_rdata  out  DATA_W  fetched word, valid with i_done, held until next i_done
- d_req  in  1  data request pulse
- d_we  in  1  1=store, 0=load, sampled with d_req
- d_addr  in  ADDR_W  data address, sampled with d_req
- d_wdata  in  DATA_W  store data, sampled with d_req
- d_done  out  1  data access complete pulse (loads and stores)
- d_rdata  out  DATA_W  load word, valid with d_done, held until next d_done; unchanged by stores
- m_en  out  1  memory access strobe, one cycle per access
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- err  out  1  sticky protocol-violation flag

## Operation
- Reset values: all outputs 0; both slots empty; FSM IDLE; last_grant=INST, so data wins the first tie.
- Each requester owns one slot: {pending, addr, we, wdata}. A req pulse loads the slot and sets pending. The slot stays busy from the req cycle until its done pulse.
- Violation: a req while that requester's slot is busy is dropped, and err is set. err is cleared only by reset.
- FSM states: IDLE, ACCESS, WAIT.
  - IDLE: the candidate set is (pending | req this cycle) per requester. If one candidate exists, grant it. If both exist, grant the one opposite last_grant and update last_grant. Register m_en=1, m_we, m_addr, m_wdata from the slot, or directly from the inputs when the req is this cycle. Go to ACCESS.
  - ACCESS: m_en=1 for this single cycle. Load cnt=LATENCY-1 and go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt=0, capture m_rdata into the granted requester's rdata (loads/fetches only), register that requester's done=1, clear its slot, and go to IDLE.
- m_we is forced 0 for fetch grants. m_addr and m_wdata hold their last value while m_en=0.
- A req arriving in the same cycle as its own done pulse is legal and is accepted.
- The ungranted requester's pulse during ACCESS/WAIT is latched and served next in IDLE.
- Reset mid-access: the access is abandoned, no done is issued, slots are cleared, and err is cleared.

## Timing
- A req in cycle t with the arbiter idle gives m_en=1 in cycle t+1; memory samples at the end of t+1.
- Done pulse and rdata appear in cycle t+2+LATENCY. With LATENCY=2 that is cycle t+4.
- Back-to-back: the next grant's m_en comes at the earliest in cycle t+3+LATENCY, giving one access per LATENCY+2 cycles.
- A requester blocked behind the other waits the full in-flight remainder plus LATENCY+2.
- Done outputs are single-cycle pulses and are never asserted together.
- No combinational path exists from any input to any output.

## Structure
- Shared package: state encoding (IDLE/ACCESS/WAIT), grant id enum (INST, DATA), and default width constants matching core word and address lengths.
- Sub-module `req_slot`, instantiated twice: pending flag, payload registers, busy tracking, and violation detect.
- Arbitration, FSM, latency counter, and return routing live in the top.

## Test plan
- Single fetch: i_req at t with i_addr=0x40, m_rdata=0xDEADBEEF at sample+2 -> m_en/m_addr=0x40 at t+1, i_done=1 and i_rdata=0xDEADBEEF at t+4, d_done stays 0.
- Store then load: d_req with we=1, addr=0x100, wdata=0x12345678 -> m_we=1 at the m_en cycle, d_done after 4 cycles, d_rdata unchanged. A following load of 0x100 with the model returning 0x12345678 -> d_rdata=0x12345678.
- Simultaneous after reset: i_req and d_req in the same cycle -> data granted first, fetch's m_en at t+5, i_done at t+8. Repeating the tie then grants fetch first.
- Request during busy: d_req issued while a fetch is in WAIT -> data m_en on the cycle after i_done+1, and err stays 0.
- Violation: a second i_req before i_done -> err=1 sticky, exactly one i_done, and the second address never appears on m_addr.
- Reset mid-access: rstn=0 in WAIT -> no done pulse, all outputs 0 next cycle, and a fresh i_req afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/load-store memory port arbiter.
// Holds the arbiter state encoding, the grant id and default widths
// matching the core's word and address lengths.
package mem_port_arbiter_pkg;

  localparam int CORE_ADDR_W = 32;
  localparam int CORE_DATA_W = 32;
  // LATENCY is limited to 1..7, so a 3-bit counter covers LATENCY-1.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

  function automatic grant_e other_grant(input grant_e g);
    return (g == GNT_INST) ? GNT_DATA : GNT_INST;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_req_slot.sv
// req_slot: one outstanding-request holder per requester.
// A req pulse loads {we, addr, wdata} and sets pending; pending stays set
// until the arbiter clears it on completion. A req while pending is
// dropped and raises the sticky err flag.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   req_i/we_i/addr_i/wdata_i  request pulse and payload
//   clr_i                completion clear from the arbiter
//   pending_o, we_o, addr_o, wdata_o  stored request
//   err_o                sticky protocol violation
module req_slot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              clr_i,
  output logic              pending_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              err_o
);

  logic              pending_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      // clr only arrives while pending, so it never races a fresh load.
      if (clr_i) pending_q <= 1'b0;
      if (req_i) begin
        if (pending_q) begin
          err_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
          we_q      <= we_i;
          addr_q    <= addr_i;
          wdata_q   <= wdata_i;
        end
      end
    end
  end

  assign pending_o = pending_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign err_o     = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-ported fixed-latency synchronous memory
// between the instruction fetch unit (read only) and the load/store unit.
// Requests are latched in per-requester slots, arbitrated round-robin on
// ties, sequenced IDLE -> ACCESS -> WAIT, and the result is routed back as
// a one-cycle done pulse with held read data.
// Ports:
//   clk, rstn                          clock, synchronous active-low reset
//   i_req, i_addr                      fetch request
//   i_done, i_rdata                    fetch completion
//   d_req, d_we, d_addr, d_wdata       data request
//   d_done, d_rdata                    data completion
//   m_en, m_we, m_addr, m_wdata, m_rdata  memory macro port
//   err                                sticky protocol violation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = CORE_ADDR_W,
  parameter int DATA_W  = CORE_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  logic              i_pend, i_slot_we, i_err, i_clr;
  logic [ADDR_W-1:0] i_slot_addr;
  logic [DATA_W-1:0] i_slot_wdata;
  logic              d_pend, d_slot_we, d_err, d_clr;
  logic [ADDR_W-1:0] d_slot_addr;
  logic [DATA_W-1:0] d_slot_wdata;

  state_e            state_q;
  grant_e            gnt_q, last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              m_en_q, m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic              i_done_q, d_done_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic              i_cand, d_cand;
  grant_e            gnt_d, last_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              last_beat;

  req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_inst (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (i_req),
    .we_i      (1'b0),
    .addr_i    (i_addr),
    .wdata_i   ({DATA_W{1'b0}}),
    .clr_i     (i_clr),
    .pending_o (i_pend),
    .we_o      (i_slot_we),
    .addr_o    (i_slot_addr),
    .wdata_o   (i_slot_wdata),
    .err_o     (i_err)
  );

  req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_data (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (d_req),
    .we_i      (d_we),
    .addr_i    (d_addr),
    .wdata_i   (d_wdata),
    .clr_i     (d_clr),
    .pending_o (d_pend),
    .we_o      (d_slot_we),
    .addr_o    (d_slot_addr),
    .wdata_o   (d_slot_wdata),
    .err_o     (d_err)
  );

  // Arbitration: a req in the current cycle counts as a candidate so an
  // idle arbiter can issue on the very next cycle; its payload comes from
  // the inputs because the slot has not loaded yet.
  always_comb begin
    i_cand = i_pend | i_req;
    d_cand = d_pend | d_req;
    last_d = last_q;
    if (i_cand && d_cand) begin
      gnt_d  = other_grant(last_q);
      last_d = gnt_d;
    end else if (d_cand) begin
      gnt_d = GNT_DATA;
    end else begin
      gnt_d = GNT_INST;
    end

    if (gnt_d == GNT_DATA) begin
      sel_we    = d_pend ? d_slot_we    : d_we;
      sel_addr  = d_pend ? d_slot_addr  : d_addr;
      sel_wdata = d_pend ? d_slot_wdata : d_wdata;
    end else begin
      sel_we    = i_pend & i_slot_we;
      sel_addr  = i_pend ? i_slot_addr  : i_addr;
      sel_wdata = i_pend ? i_slot_wdata : '0;
    end
  end

  assign last_beat = (state_q == ST_WAIT) && (cnt_q == '0);
  assign i_clr     = last_beat && (gnt_q == GNT_INST);
  assign d_clr     = last_beat && (gnt_q == GNT_DATA);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_INST;
      last_q    <= GNT_INST;
      cnt_q     <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      m_en_q   <= 1'b0;
      m_we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_cand || d_cand) begin
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            m_en_q    <= 1'b1;
            // Fetches never write, whatever the slot holds.
            m_we_q    <= (gnt_d == GNT_DATA) && sel_we;
            m_addr_q  <= sel_addr;
            m_wdata_q <= sel_wdata;
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt_q   <= CNT_W'(LATENCY - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (gnt_q == GNT_INST) begin
              i_done_q  <= 1'b1;
              i_rdata_q <= m_rdata;
            end else begin
              d_done_q <= 1'b1;
              if (!m_we_hold()) d_rdata_q <= m_rdata;
            end
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Whether the in-flight data access is a store: the data slot still
  // holds the granted request until its completion clear.
  function automatic logic m_we_hold();
    return d_slot_we;
  endfunction

  assign i_done  = i_done_q;
  assign i_rdata = i_rdata_q;
  assign d_done  = d_done_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign err     = i_err | d_err;

endmodule
